slave_port_burst: RTL

Parametrised burst-capable successor to the bus slave port. Sits between the serial system bus (address/data lines, valid/ready handshakes) and one slave's synchronous memory. Deserialises a header (start address + burst length) and write beats, serialises read beats. Drives memory strobes with address auto-increment and out-of-range detection.

---
 rtl/slave_port_pkg.sv | 28 ++
 rtl/bit_shift_reg.sv | 37 +++
 rtl/slave_port_burst.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slave_port_pkg
// Purpose  : Shared states and header sizing for the burst slave port.
// Revision : 1.0
// ============================================================================
package slave_port_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int LEN_WIDTH_DEF  = 2;
    localparam int HDR_BITS       = ADDR_WIDTH_DEF + LEN_WIDTH_DEF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_WDATA = 3'd2,
        S_WRITE = 3'd3,
        S_RREQ  = 3'd4,
        S_RWAIT = 3'd5,
        S_TX    = 3'd6
    } state_t;

    function automatic int hdr_bits(input int addr_width, input int len_width);
        return addr_width + len_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : bit_shift_reg
// Purpose  : LSB-first shifter: serial-in/parallel-out and parallel-load/serial-out.
// Revision : 1.0
// ============================================================================
module bit_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out
);

    logic [WIDTH-1:0] r_q;

    // New bits enter at the MSB so the first bit received ends up lowest.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= load_data;
        end else if (shift_en) begin
            r_q <= {serial_in, r_q[WIDTH-1:1]};
        end
    end

    assign parallel_out = r_q;
    assign serial_out   = r_q[0];

endmodule
`default_nettype wire

// File: rtl/slave_port_burst.sv
`default_nettype none
// ============================================================================
// Module   : slave_port_burst
// Purpose  : Burst slave port between the serial bus and a synchronous memory.
// Revision : 1.0
// ============================================================================
module slave_port_burst
    import slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic                  master_valid,
    output logic                  slave_ready,
    input  logic                  rx_address,
    input  logic                  rx_data,
    output logic                  tx_data,
    output logic                  slave_valid,
    input  logic                  master_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  addr_err,
    output logic                  xfer_done
);

    localparam int HDR_W = hdr_bits(ADDR_WIDTH, LEN_WIDTH);
    localparam int RX_W  = (HDR_W > DATA_WIDTH) ? HDR_W : DATA_WIDTH;
    localparam int CNT_W = $clog2(RX_W + 1);

    localparam logic [CNT_W-1:0]      HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [LEN_WIDTH:0]    BEATS_ONE = (LEN_WIDTH + 1)'(1);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [LEN_WIDTH:0]    r_beats;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_is_write;
    logic                  r_oor;
    logic                  r_addr_err;
    logic                  r_done;

    logic                  w_rx_shift;
    logic                  w_tx_shift;
    logic                  w_tx_load;
    logic                  w_bit_last;
    logic                  w_beat_end;
    logic [RX_W-1:0]       w_rx_q;
    logic [RX_W-1:0]       w_rx_next;
    logic                  w_rx_serial;
    logic [DATA_WIDTH-1:0] w_tx_q;
    logic                  w_tx_serial;
    logic [DATA_WIDTH-1:0] w_tx_load_data;
    logic [HDR_W-1:0]      w_hdr;
    logic [ADDR_WIDTH-1:0] w_hdr_addr;
    logic [LEN_WIDTH-1:0]  w_hdr_len;
    logic                  w_hdr_oor;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_unused;

    bit_shift_reg #(.WIDTH(RX_W)) u_rx_shift (
        .clk          (clk),
        .reset        (reset),
        .load         (1'b0),
        .load_data    ({RX_W{1'b0}}),
        .shift_en     (w_rx_shift),
        .serial_in    ((r_state == S_HDR) ? rx_address : rx_data),
        .parallel_out (w_rx_q),
        .serial_out   (w_rx_serial)
    );

    bit_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx_shift (
        .clk          (clk),
        .reset        (reset),
        .load         (w_tx_load),
        .load_data    (w_tx_load_data),
        .shift_en     (w_tx_shift),
        .serial_in    (1'b0),
        .parallel_out (w_tx_q),
        .serial_out   (w_tx_serial)
    );

    // Header is decoded from the value the shifter is about to hold, so the
    // address is registered on the same edge as the last header bit.
    assign w_rx_next  = {((r_state == S_HDR) ? rx_address : rx_data), w_rx_q[RX_W-1:1]};
    assign w_hdr      = w_rx_next[RX_W-1 -: HDR_W];
    assign w_hdr_addr = w_hdr[ADDR_WIDTH-1:0];
    assign w_hdr_len  = w_hdr[HDR_W-1 -: LEN_WIDTH];
    assign w_hdr_oor  = ({1'b0, w_hdr_addr} >= DEPTH_EXT);
    assign w_addr_inc = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);

    // Out-of-range reads still stream beats, just zeros instead of memory data.
    assign w_tx_load_data = r_oor ? '0 : mem_rdata;
    assign w_beat_end     = (r_state == S_WRITE) || ((r_state == S_TX) && w_bit_last);

    assign mem_addr  = r_addr;
    assign mem_wdata = w_rx_q[RX_W-1 -: DATA_WIDTH];
    assign tx_data   = (r_state == S_TX) && w_tx_serial;
    assign addr_err  = r_addr_err;
    assign xfer_done = r_done;
    assign w_unused  = ^{w_rx_next, w_rx_serial, w_tx_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        mem_wr_en   = 1'b0;
        mem_rd_en   = 1'b0;
        w_rx_shift  = 1'b0;
        w_tx_shift  = 1'b0;
        w_tx_load   = 1'b0;
        w_bit_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (read_en ^ write_en) w_next = S_HDR;
            end
            S_HDR: begin
                slave_ready = 1'b1;
                if (master_valid) begin
                    w_rx_shift = 1'b1;
                    if (r_bit_cnt == HDR_LAST) begin
                        w_bit_last = 1'b1;
                        w_next     = r_is_write ? S_WDATA : S_RREQ;
                    end
                end
            end
            S_WDATA: begin
                slave_ready = 1'b1;
                if (master_valid) begin
                    w_rx_shift = 1'b1;
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_last = 1'b1;
                        w_next     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_wr_en = ~r_oor;
                w_next    = (r_beats == BEATS_ONE) ? S_IDLE : S_WDATA;
            end
            S_RREQ: begin
                mem_rd_en = ~r_oor;
                w_next    = S_RWAIT;
            end
            S_RWAIT: begin
                w_tx_load = 1'b1;
                w_next    = S_TX;
            end
            S_TX: begin
                slave_valid = 1'b1;
                if (master_ready) begin
                    w_tx_shift = 1'b1;
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_last = 1'b1;
                        w_next     = (r_beats == BEATS_ONE) ? S_IDLE : S_RREQ;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_beats    <= '0;
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_oor      <= 1'b0;
            r_addr_err <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            r_done     <= 1'b0;
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                if (read_en && write_en) begin
                    r_addr_err <= 1'b1;
                end else if (read_en || write_en) begin
                    r_is_write <= write_en;
                end
            end
            if (w_rx_shift || w_tx_shift) begin
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + CNT_W'(1);
            end
            if ((r_state == S_HDR) && w_bit_last) begin
                r_addr     <= w_hdr_addr;
                r_beats    <= {1'b0, w_hdr_len} + BEATS_ONE;
                r_oor      <= w_hdr_oor;
                r_addr_err <= w_hdr_oor;
            end
            if (w_beat_end) begin
                if (r_beats == BEATS_ONE) begin
                    r_done <= 1'b1;
                end else begin
                    r_addr  <= w_addr_inc;
                    r_beats <= r_beats - BEATS_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire
